// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external ALU between two requesters.
// Define ALU_ARB_ERR_EN to answer reserved opcode 11 immediately with rsp_err instead of issuing it.
module alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_valid_i,
    output logic [1:0] req_ready_o,
    input  logic [1:0] req0_op_i,
    input  logic [2:0] req0_a_i,
    input  logic [2:0] req0_b_i,
    input  logic [1:0] req1_op_i,
    input  logic [2:0] req1_a_i,
    input  logic [2:0] req1_b_i,
    output logic [1:0] alu_op_o,
    output logic [2:0] alu_a_o,
    output logic [2:0] alu_b_o,
    input  logic [4:0] alu_result_i,
    input  logic       alu_zero_i,
    input  logic       alu_neg_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic       rsp_id_o,
    output logic [4:0] rsp_result_o,
    output logic       rsp_zero_o,
    output logic       rsp_neg_o,
    output logic       rsp_err_o,
    output logic       busy_o
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    state_e     state_q;
    logic       last_grant_q;
    logic [3:0] cnt_q;
    logic [1:0] alu_op_q;
    logic [2:0] alu_a_q, alu_b_q;
    logic       rsp_id_q, rsp_zero_q, rsp_neg_q, rsp_err_q;
    logic [4:0] rsp_result_q;
    logic [1:0] grant;
    logic       win, is_err;
    logic [1:0] win_op;
    logic [2:0] win_a, win_b;

    // On contention the requester that did not win last time goes first.
    assign grant  = (req_valid_i == 2'b11) ? (last_grant_q ? 2'b01 : 2'b10) : req_valid_i;
    assign win    = grant[1];
    assign win_op = win ? req1_op_i : req0_op_i;
    assign win_a  = win ? req1_a_i : req0_a_i;
    assign win_b  = win ? req1_b_i : req0_b_i;
`ifdef ALU_ARB_ERR_EN
    assign is_err = (win_op == 2'b11);
`else
    assign is_err = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_neg_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (grant != 2'b00) begin
                    rsp_id_q     <= win;
                    last_grant_q <= win;
                    if (is_err) begin
                        rsp_err_q    <= 1'b1;
                        rsp_result_q <= '0;
                        rsp_zero_q   <= 1'b0;
                        rsp_neg_q    <= 1'b0;
                        state_q      <= RESP;
                    end else begin
                        alu_op_q <= win_op;
                        alu_a_q  <= win_a;
                        alu_b_q  <= win_b;
                        cnt_q    <= CNT_INIT;
                        state_q  <= EXEC;
                    end
                end
                EXEC: if (cnt_q == '0) begin
                    rsp_result_q <= alu_result_i;
                    rsp_zero_q   <= alu_zero_i;
                    rsp_neg_q    <= alu_neg_i;
                    rsp_err_q    <= 1'b0;
                    state_q      <= RESP;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                RESP: if (rsp_ready_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gating with rst_ni keeps req_ready low while reset is held.
    assign req_ready_o  = (state_q == IDLE && rst_ni) ? grant : 2'b00;
    assign alu_op_o     = alu_op_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign rsp_valid_o  = (state_q == RESP);
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_zero_o   = rsp_zero_q;
    assign rsp_neg_o    = rsp_neg_q;
    assign rsp_err_o    = rsp_err_q;
    assign busy_o       = (state_q != IDLE);
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one ALU (add/sub/mul on 3-bit sign-magnitude operands, 5-bit result, zero/negative flags) between two requesters. Round-robin arbitration over valid/ready request channels, operand latching, ALU-latency sequencing, and a single registered response channel tagged with the requester id. Sits between the instruction front-ends and the ALU datapath; the ALU itself is external.

## Interface
- `ALU_LAT`, default 1: ALU cycles from operand presentation to result sampling; legal range 1..15.

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `req_valid`  in  2  bit i = requester i has a request
- `req_ready`  out  2  bit i = request i accepted this cycle
- `req0_op` / `req1_op`  in  2  opcode: 00 add, 01 sub, 10 mul, 11 reserved
- `req0_a` / `req1_a`  in  3  operand A, bit 2 sign, bits 1:0 magnitude
- `req0_b` / `req1_b`  in  3  operand B, same format
- `alu_op`  out  2  opcode to ALU
- `alu_a`, `alu_b`  out  3  operands to ALU
- `alu_result`  in  5  ALU result
- `alu_zero`, `alu_neg`  in  1  ALU flags
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  consumer takes response
- `rsp_id`  out  1  requester that issued the response
- `rsp_result`  out  5  captured result
- `rsp_zero`, `rsp_neg`  out  1  captured flags
- `rsp_err`  out  1  reserved-opcode error (see Configuration)
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: grant is computed combinationally from `req_valid` and the pointer `last_grant`.
  - Exactly one requester valid: that requester wins.
  - Both valid: the requester not equal to `last_grant` wins.
  - `req_ready` is one-hot on the winner, or zero when nothing is valid. Never asserted outside IDLE.
- Accept (valid & ready): latch winner's op/a/b into the `alu_*` registers, latch `rsp_id`, update `last_grant` to the winner, load the cycle counter with ALU_LAT-1, go to EXEC.
- EXEC: `alu_*` outputs are held stable. The counter decrements each cycle. On the cycle where the counter is 0:
  - capture `alu_result`, `alu_zero`, `alu_neg` into the `rsp_*` registers;
  - clear `rsp_err`;
  - go to RESP.
- RESP: `rsp_valid`=1. All `rsp_*` outputs are held stable until `rsp_ready`=1. On that handshake, go to IDLE.
  - A new accept is not possible in the same cycle; the earliest accept is the next cycle.
- `alu_*` outputs retain their last values in IDLE and RESP.
- Requester valid/ready rule: a requester must hold its request stable while valid and not ready. The block does not check this.

## Timing
- Reset values: `req_ready`=0, `alu_op`/`alu_a`/`alu_b`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_zero`=0, `rsp_neg`=0, `rsp_err`=0, `busy`=0, `last_grant`=1 (requester 0 wins first contention).
- Accept at edge of cycle T:
  - `alu_*` valid from cycle T+1;
  - result sampled at the edge ending cycle T+ALU_LAT;
  - `rsp_valid` high from cycle T+ALU_LAT+1.
- Best-case throughput: one operation per ALU_LAT+2 cycles.
- `rsp_ready` held high while waiting: RESP lasts 1 cycle.
- Reset asserted mid-operation: the in-flight transaction is dropped with no response, and all registers return to reset values immediately.
- A `rsp_ready` pulse while `rsp_valid`=0 is ignored.

## Configuration
- `ALU_ARB_ERR_EN` defined:
  - an accepted request with op 11 bypasses EXEC and goes directly to RESP;
  - response: `rsp_err`=1, `rsp_result`=0, `rsp_zero`=0, `rsp_neg`=0;
  - `rsp_valid` high from cycle T+1;
  - `alu_*` are not updated.
- Not defined: op 11 is issued to the ALU like any other opcode, and `rsp_err` is tied 0.

## Test plan
- Reset, then requester 0 only: op 10, a=3'b011, b=3'b010, ALU model returns 5'b00110. Required: `req_ready`=2'b01 for one cycle; `rsp_valid` at T+ALU_LAT+1; `rsp_id`=0, `rsp_result`=00110, `rsp_zero`=0, `rsp_neg`=0.
- Both requesters valid continuously, `rsp_ready`=1. Required: grants alternate 0,1,0,1; four responses with `rsp_id` sequence 0,1,0,1; each grant spaced ALU_LAT+2 cycles apart.
- `rsp_ready` held 0 for 5 cycles during RESP, requester 1 valid. Required: `rsp_*` stable for all 5 cycles; `req_ready`=0 throughout; grant to 1 occurs the cycle after `rsp_ready` rises.
- ALU_LAT=4, `alu_result` changes on every EXEC cycle. Required: captured value equals the value present in the 4th EXEC cycle; `alu_*` outputs constant through EXEC.
- `rst_n` pulled low during EXEC. Required: all outputs 0 asynchronously; no response after release; the first grant after reset goes to requester 0 under contention.
- With `ALU_ARB_ERR_EN`, op 11 from requester 1. Required: `rsp_valid` at T+1 with `rsp_err`=1, `rsp_id`=1, `rsp_result`=0, and `alu_*` unchanged. Without the macro, the same request produces a normal ALU-latency response with `rsp_err`=0.
